dmem_arbiter: RTL and testbench

- Shares the single data-memory port (d_address / d_data_write / d_write_enable / d_data_valid) between two requesters: port 0 is the pipeline MEM stage, port 1 is a secondary master (debug/DMA loader).
- Round-robin arbitration, one outstanding access at a time, completion on d_data_valid, and a timeout that terminates hung accesses with an error.
- Generates the MEM-stage stall that freezes the pipeline while its access is pending.

---
 rtl/dmem_arbiter.sv | 137 +++++++++++++
 tb/tb_dmem_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the MEM stage (port 0)
// and a secondary master (port 1), with access timeout and MEM-stage stall.
module dmem_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_ack,
    output logic          m0_err,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_ack,
    output logic          m1_err,
    output logic          mem_stall,
    output logic          d_req,
    output logic          d_write_enable,
    output logic [AW-1:0] d_address,
    output logic [DW-1:0] d_data_write,
    input  logic [DW-1:0] d_data_read,
    input  logic          d_data_valid
);

    typedef enum logic {StIdle, StBusy} state_e;

    state_e        r_state;
    state_e        w_state_next;
    logic          r_last_grant;  // doubles as the current grant while BUSY
    logic [7:0]    r_cnt;
    logic          r_d_req;
    logic          r_d_we;
    logic [AW-1:0] r_d_addr;
    logic [DW-1:0] r_d_wdata;

    logic w_any_req;
    logic w_grant_sel;
    logic w_busy;
    logic w_timeout;
    logic w_done;

    assign w_any_req = m0_req | m1_req;
    assign w_busy    = (r_state == StBusy);
    // Valid in the timeout cycle takes priority, so the timeout only counts without valid
    assign w_timeout = w_busy & ~d_data_valid & (r_cnt == 8'(TIMEOUT - 1));
    assign w_done    = w_busy & (d_data_valid | w_timeout);

    always_comb begin
        if (m0_req && m1_req) begin
            w_grant_sel = ~r_last_grant;
        end else begin
            w_grant_sel = ~m0_req;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: if (w_any_req) w_state_next = StBusy;
            StBusy: if (w_done)    w_state_next = StIdle;
            default:               w_state_next = StIdle;
        endcase
    end

    // Completion outputs
    always_comb begin
        m0_ack   = 1'b0;
        m1_ack   = 1'b0;
        m0_err   = 1'b0;
        m1_err   = 1'b0;
        m0_rdata = '0;
        m1_rdata = '0;
        if (w_done) begin
            if (r_last_grant == 1'b0) begin
                m0_ack   = 1'b1;
                m0_err   = w_timeout;
                m0_rdata = d_data_valid ? d_data_read : '0;
            end else begin
                m1_ack   = 1'b1;
                m1_err   = w_timeout;
                m1_rdata = d_data_valid ? d_data_read : '0;
            end
        end
    end

    assign mem_stall = m0_req & ~m0_ack;

    // Memory-side datapath, grant and timeout counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_grant <= 1'b1;
            r_cnt        <= '0;
            r_d_req      <= 1'b0;
            r_d_we       <= 1'b0;
            r_d_addr     <= '0;
            r_d_wdata    <= '0;
        end else if (r_state == StIdle) begin
            if (w_any_req) begin
                r_last_grant <= w_grant_sel;
                r_cnt        <= '0;
                r_d_req      <= 1'b1;
                r_d_we       <= w_grant_sel ? m1_we : m0_we;
                r_d_addr     <= w_grant_sel ? m1_addr : m0_addr;
                r_d_wdata    <= w_grant_sel ? m1_wdata : m0_wdata;
            end
        end else if (w_done) begin
            r_d_req <= 1'b0;
            r_d_we  <= 1'b0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign d_req          = r_d_req;
    assign d_write_enable = r_d_we;
    assign d_address      = r_d_addr;
    assign d_data_write   = r_d_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and randomized checks of dmem_arbiter against a transaction-level model.
module tb_dmem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 16;

    logic          clk;
    logic          reset_n;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata;
    logic          m0_ack, m0_err, m1_ack, m1_err, mem_stall;
    logic          d_req, d_write_enable, d_data_valid;
    logic [AW-1:0] d_address;
    logic [DW-1:0] d_data_write, d_data_read;

    int vectors;
    int miscompares;

    dmem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .m0_req         (m0_req),
        .m0_we          (m0_we),
        .m0_addr        (m0_addr),
        .m0_wdata       (m0_wdata),
        .m0_rdata       (m0_rdata),
        .m0_ack         (m0_ack),
        .m0_err         (m0_err),
        .m1_req         (m1_req),
        .m1_we          (m1_we),
        .m1_addr        (m1_addr),
        .m1_wdata       (m1_wdata),
        .m1_rdata       (m1_rdata),
        .m1_ack         (m1_ack),
        .m1_err         (m1_err),
        .mem_stall      (mem_stall),
        .d_req          (d_req),
        .d_write_enable (d_write_enable),
        .d_address      (d_address),
        .d_data_write   (d_data_write),
        .d_data_read    (d_data_read),
        .d_data_valid   (d_data_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
        d_data_valid = 0; d_data_read = '0;
    endtask

    task automatic do_reset();
        reset_n = 0;
        clear_inputs();
        repeat (2) tick();
        reset_n = 1;
    endtask

    // Transaction-level reference state for the random phase
    bit            busy, last, fin, vld, rq [2], wq [2], t_we;
    int            port, age, lat;
    logic [AW-1:0] aq [2], t_addr;
    logic [DW-1:0] dq [2], t_wdata;
    logic          e_ack [2], e_err [2];
    logic [DW-1:0] e_rd [2];

    initial begin
        vectors     = 0;
        miscompares = 0;

        // Reset values
        reset_n = 0;
        clear_inputs();
        #3;
        chk("rst_dreq", d_req, 0);
        chk("rst_dwe", d_write_enable, 0);
        chk("rst_daddr", d_address, 0);
        chk("rst_dwdata", d_data_write, 0);
        chk("rst_acks", {m0_ack, m1_ack, m0_err, m1_err}, 0);
        do_reset();

        // Single read, memory answers in the second BUSY cycle
        tick(); m0_req = 1; m0_we = 0; m0_addr = 32'h100; #1;
        chk("rd_idle_dreq", d_req, 0);
        chk("rd_idle_stall", mem_stall, 1);
        tick(); #1;
        chk("rd_b1_dreq", d_req, 1);
        chk("rd_b1_addr", d_address, 32'h100);
        chk("rd_b1_ack", m0_ack, 0);
        chk("rd_b1_stall", mem_stall, 1);
        tick(); d_data_valid = 1; d_data_read = 32'hDEADBEEF; #1;
        chk("rd_b2_dreq", d_req, 1);
        chk("rd_b2_ack", m0_ack, 1);
        chk("rd_b2_rdata", m0_rdata, 32'hDEADBEEF);
        chk("rd_b2_err", m0_err, 0);
        chk("rd_b2_stall", mem_stall, 0);
        chk("rd_b2_m1", {m1_ack, m1_rdata}, 0);
        tick(); m0_req = 0; d_data_valid = 0; #1;
        chk("rd_done_dreq", d_req, 0);
        chk("rd_done_ack", m0_ack, 0);
        chk("rd_done_addr", d_address, 32'h100);

        // Contention: alternating grants from port 0
        do_reset();
        m0_req = 1; m0_addr = 32'hA0; m1_req = 1; m1_addr = 32'hB0;
        for (int k = 0; k < 8; k++) begin
            tick(); d_data_valid = (k % 2 == 1); #1;
            chk("cont_ack0", m0_ack, (k % 4 == 1));
            chk("cont_ack1", m1_ack, (k % 4 == 3));
            if (k % 2 == 1) chk("cont_addr", d_address, (k % 4 == 1) ? 32'hA0 : 32'hB0);
        end
        tick(); m0_req = 0; m1_req = 0; d_data_valid = 0; #1;

        // Write from port 1, valid in third BUSY cycle
        tick(); m1_req = 1; m1_we = 1; m1_addr = 32'h20; m1_wdata = 32'h55; #1;
        for (int i = 1; i <= 3; i++) begin
            tick(); d_data_valid = (i == 3); d_data_read = 32'h12345678; #1;
            chk("wr_we", d_write_enable, 1);
            chk("wr_addr", d_address, 32'h20);
            chk("wr_data", d_data_write, 32'h55);
            chk("wr_ack1", m1_ack, (i == 3));
            chk("wr_m0", {m0_ack, m0_rdata}, 0);
        end
        tick(); m1_req = 0; m1_we = 0; d_data_valid = 0; #1;
        chk("wr_idle_we", d_write_enable, 0);
        chk("wr_idle_dreq", d_req, 0);

        // Timeout on port 0, then port 1 served normally
        tick(); m0_req = 1; m0_addr = 32'h300; #1;
        for (int i = 1; i <= int'(TO); i++) begin
            tick(); d_data_read = 32'hCAFE; #1;
            chk("to_ack", m0_ack, (i == int'(TO)));
            if (i == int'(TO)) begin
                chk("to_err", m0_err, 1);
                chk("to_rdata", m0_rdata, 0);
            end
        end
        tick(); m0_req = 0; m1_req = 1; m1_addr = 32'h40; #1;
        chk("to_idle", {d_req, m0_ack}, 0);
        tick(); d_data_valid = 1; d_data_read = 32'h77; #1;
        chk("to_m1_addr", d_address, 32'h40);
        chk("to_m1_ack", {m1_ack, m1_err}, 2'b10);
        chk("to_m1_rdata", m1_rdata, 32'h77);
        tick(); m1_req = 0; d_data_valid = 0; #1;

        // Valid coinciding with the timeout cycle, then a spurious valid in IDLE
        tick(); m0_req = 1; m0_addr = 32'h500; #1;
        for (int i = 1; i <= int'(TO); i++) begin
            tick(); d_data_valid = (i == int'(TO)); d_data_read = 32'hABCD; #1;
            if (i == int'(TO)) chk("co_ack_err", {m0_ack, m0_err}, 2'b10);
            if (i == int'(TO)) chk("co_rdata", m0_rdata, 32'hABCD);
        end
        tick(); m0_req = 0; d_data_valid = 1; #1;
        chk("spur_acks", {m0_ack, m1_ack}, 0);
        tick(); d_data_valid = 0; #1;
        chk("spur_dreq", d_req, 0);

        // Reset in the middle of BUSY
        tick(); m0_req = 1; m0_addr = 32'h600; #1;
        repeat (3) tick();
        d_data_valid = 1; reset_n = 0; #1;
        chk("mid_rst_dreq", d_req, 0);
        chk("mid_rst_addr", d_address, 0);
        chk("mid_rst_acks", {m0_ack, m0_err, m1_ack, m1_err}, 0);
        tick(); d_data_valid = 0; m1_req = 1; m1_addr = 32'h700; reset_n = 1; #1;
        chk("mid_rel_dreq", d_req, 0);
        tick(); #1;
        chk("mid_first_grant", d_address, 32'h600);

        // Randomized traffic against the transaction model
        do_reset();
        busy = 0; last = 1; port = 0; age = 0; lat = 0;
        for (int p = 0; p < 2; p++) begin
            rq[p] = 0; wq[p] = 0; aq[p] = '0; dq[p] = '0;
        end
        for (int n = 0; n < 600; n++) begin
            tick();
            for (int p = 0; p < 2; p++) begin
                if (!rq[p] && $urandom_range(0, 2) == 0) begin
                    rq[p] = 1; wq[p] = 1'($urandom); aq[p] = $urandom; dq[p] = $urandom;
                end
            end
            m0_req = rq[0]; m0_we = wq[0]; m0_addr = aq[0]; m0_wdata = dq[0];
            m1_req = rq[1]; m1_we = wq[1]; m1_addr = aq[1]; m1_wdata = dq[1];
            vld = busy ? (age == lat) : ($urandom_range(0, 7) == 0);
            d_data_valid = vld;
            d_data_read  = $urandom;
            #1;
            fin = busy && (vld || age == int'(TO));
            for (int p = 0; p < 2; p++) begin
                e_ack[p] = fin && (port == p);
                e_err[p] = fin && (port == p) && !vld;
                e_rd[p]  = (fin && (port == p) && vld) ? d_data_read : '0;
            end
            chk("rnd_dreq", d_req, busy);
            if (busy) begin
                chk("rnd_addr", d_address, t_addr);
                chk("rnd_we", d_write_enable, t_we);
                if (t_we) chk("rnd_wdata", d_data_write, t_wdata);
            end
            chk("rnd_ack0", {m0_ack, m0_err}, {e_ack[0], e_err[0]});
            chk("rnd_ack1", {m1_ack, m1_err}, {e_ack[1], e_err[1]});
            chk("rnd_rdata0", m0_rdata, e_rd[0]);
            chk("rnd_rdata1", m1_rdata, e_rd[1]);
            chk("rnd_stall", mem_stall, rq[0] && !e_ack[0]);
            if (busy) begin
                if (fin) begin
                    busy = 0;
                    rq[port] = 0;
                end else begin
                    age++;
                end
            end else if (rq[0] || rq[1]) begin
                port = (rq[0] && rq[1]) ? int'(!last) : (rq[0] ? 0 : 1);
                last = (port == 1);
                busy = 1; age = 1;
                lat = $urandom_range(1, TO + 3);
                t_addr = aq[port]; t_we = wq[port]; t_wdata = dq[port];
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
